// File: rtl/skut_frame_pingpong_pkg.sv
// Shared definitions for the SKUT ping-pong frame buffer.
// Contents:
//   UNDERRUN_REPEAT / UNDERRUN_FILL : values of the UNDERRUN_MODE parameter
//   SKUT_DATA_W / SKUT_ADDR_W       : default word and address widths
//   bank_e                          : identifies one of the two frame banks
package skut_pkg;

  localparam int UNDERRUN_REPEAT = 0;  // replay the previous frame on underrun
  localparam int UNDERRUN_FILL   = 1;  // output FILL_VALUE for the whole frame

  localparam int SKUT_DATA_W = 8;
  localparam int SKUT_ADDR_W = 7;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

endpackage : skut_pkg

// File: rtl/skut_frame_pingpong_if.sv
// Bus bundle between the SKUT frame former / DAC distributor and the ping-pong buffer.
// Signals:
//   writer : wr_en, wr_addr, wr_data, wr_frame_done (pulse)
//   reader : rd_sync (pulse), rd_en, rd_addr -> rd_data, rd_valid
//   status : rd_bank, swap, underrun, overrun, underrun_cnt, overrun_cnt
// Modports:
//   master : the side driving writes/reads (frame former + distributor, or a bench)
//   slave  : the buffer itself
interface skut_frame_pingpong_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;

  logic              rd_sync;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              rd_bank;
  logic              swap;
  logic              underrun;
  logic              overrun;
  logic [CNT_W-1:0]  underrun_cnt;
  logic [CNT_W-1:0]  overrun_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, wr_frame_done,
    output rd_sync, rd_en, rd_addr,
    input  rd_data, rd_valid,
    input  rd_bank, swap, underrun, overrun, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_frame_done,
    input  rd_sync, rd_en, rd_addr,
    output rd_data, rd_valid,
    output rd_bank, swap, underrun, overrun, underrun_cnt, overrun_cnt
  );

endinterface : skut_frame_pingpong_if

// File: rtl/skut_dp_bank.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
// Ports:
//   clk, rst_n        : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read enable/address; rdata_o updates the cycle after re_i
//   rdata_o           : registered read data, holds while re_i=0
module skut_dp_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : skut_dp_bank

// File: rtl/skut_frame_pingpong.sv
// Ping-pong frame buffer between the SKUT frame former (writer) and DAC distributor (reader).
// Banks swap only at a reader frame sync, and only if the writer completed a frame since
// the last swap; otherwise the sync is an underrun. A completed frame that is never read
// before the next one completes is an overrun (the newer frame wins).
// Ports:
//   clk, rst_n : clock and async active-low reset
//   bus        : skut_frame_pingpong_if slave modport (write, read and status signals)
module skut_frame_pingpong
  import skut_pkg::*;
#(
  parameter int               DATA_W        = SKUT_DATA_W,
  parameter int               ADDR_W        = SKUT_ADDR_W,
  parameter int               UNDERRUN_MODE = UNDERRUN_REPEAT,
  parameter logic [DATA_W-1:0] FILL_VALUE   = '0,
  parameter int               CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  skut_frame_pingpong_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bank-select state and status registers
  bank_e            rd_bank_q, rd_bank_d;
  logic             ready_q, ready_d;
  logic             fill_q, fill_d;
  logic             swap_q, swap_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] ucnt_q, ucnt_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             ready_eff;

  // Read-path registers: which bank / fill state the last read was taken from
  bank_e            rd_sel_q;
  logic             fill_sel_q;
  logic             rd_valid_q;

  bank_e             wr_bank;
  logic [1:0]        bank_we;
  logic [1:0]        bank_re;
  logic [DATA_W-1:0] bank_rdata [2];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_bank_d  = rd_bank_q;
    ready_d    = ready_q;
    fill_d     = fill_q;
    swap_d     = 1'b0;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    ucnt_d     = ucnt_q;
    ocnt_d     = ocnt_q;
    // A done arriving with the sync counts as ready, and is consumed by that swap.
    ready_eff  = ready_q | bus.wr_frame_done;

    if (bus.rd_sync) begin
      if (ready_eff) begin
        rd_bank_d = bank_e'(~rd_bank_q);
        swap_d    = 1'b1;
        ready_d   = 1'b0;
        fill_d    = 1'b0;
      end else begin
        underrun_d = 1'b1;
        ucnt_d     = (ucnt_q == CNT_MAX) ? ucnt_q : ucnt_q + CNT_W'(1);
        if (UNDERRUN_MODE == UNDERRUN_FILL) begin
          fill_d = 1'b1;
        end
      end
    end else if (bus.wr_frame_done) begin
      ready_d = 1'b1;
      if (ready_q) begin
        overrun_d = 1'b1;
        ocnt_d    = (ocnt_q == CNT_MAX) ? ocnt_q : ocnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q  <= BANK_0;
      ready_q    <= 1'b0;
      fill_q     <= 1'b0;
      swap_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      ucnt_q     <= '0;
      ocnt_q     <= '0;
    end else begin
      rd_bank_q  <= rd_bank_d;
      ready_q    <= ready_d;
      fill_q     <= fill_d;
      swap_q     <= swap_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      ucnt_q     <= ucnt_d;
      ocnt_q     <= ocnt_d;
    end
  end

  // Writes follow the next-state bank so a write in the swap cycle lands in the new
  // write bank; reads follow the current bank so a read in the swap cycle is pre-swap.
  assign wr_bank = bank_e'(~rd_bank_d);

  always_comb begin
    bank_we = 2'b00;
    bank_re = 2'b00;
    bank_we[wr_bank]   = bus.wr_en;
    bank_re[rd_bank_q] = bus.rd_en;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skut_dp_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (bank_we[b]),
      .waddr_i (bus.wr_addr),
      .wdata_i (bus.wr_data),
      .re_i    (bank_re[b]),
      .raddr_i (bus.rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  // The output mux selects on state captured with the read, so rd_data holds while
  // rd_en=0 even across a swap or a change of fill state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q   <= BANK_0;
      fill_sel_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_sel_q   <= rd_bank_q;
        fill_sel_q <= fill_q;
      end
    end
  end

  assign bus.rd_data      = fill_sel_q ? FILL_VALUE : bank_rdata[rd_sel_q];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.swap         = swap_q;
  assign bus.underrun     = underrun_q;
  assign bus.overrun      = overrun_q;
  assign bus.underrun_cnt = ucnt_q;
  assign bus.overrun_cnt  = ocnt_q;

endmodule : skut_frame_pingpong
